lcd_text_ctrl: RTL and testbench
================================

Name: lcd_text_ctrl

Overview:
- Parametrised HD44780 (LCD1602/LCD2004) text controller, 8-bit bus, write-only.
- Runs the power-up init sequence itself, then serves character, cursor and clear requests through a valid/ready handshake.
- Generates bus timing (setup / EN pulse / hold / exec wait) as cycle counts on iclk. No derived clock.
- Tracks the cursor (row, col) and wraps lines automatically. Sits between the keyboard/text-source logic and the LCD pins.

Parameters:
- N_COLS, 16, visible columns per row (1..40)
- N_ROWS, 2, rows (1, 2 or 4)
- PWR_CYC, 1_080_000, power-up wait before first command (40 ms @ 27 MHz)
- SETUP_CYC, 2, cycles DATA/RS stable before EN rises
- EN_CYC, 14, EN high cycles
- HOLD_CYC, 2, cycles DATA/RS held after EN falls
- CMD_WAIT_CYC, 1350, exec wait after normal command/data (50 us)
- CLR_WAIT_CYC, 54_000, exec wait after clear (2 ms)
- CURSOR_BLINK, 1, 1: display-on command 0x0F; 0: 0x0C

Ports:
- iclk  in  1  system clock
- irst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_op  in  2  0 CHAR, 1 LEFT, 2 RIGHT, 3 CLEAR
- req_data  in  8  ASCII code (CHAR only)
- req_ready  out  1  controller idle; request accepted when valid&&ready
- init_done  out  1  init sequence complete (sticky until reset)
- cur_row  out  $clog2(N_ROWS) or 1  current cursor row
- cur_col  out  $clog2(N_COLS)  current cursor column
- LCD_DATA  out  8  bus data
- LCD_RS  out  1  0 command, 1 data
- LCD_RW  out  1  constant 0
- LCD_EN  out  1  enable strobe

Behaviour:
- Reset (async, irst=0):
  - LCD_EN=0, LCD_RS=0, LCD_DATA=0, req_ready=0, init_done=0, cur_row=0, cur_col=0.
  - FSM enters PWR and all counters clear.
  - Reset mid-transaction aborts immediately: EN drops in the same reset event.
- All LCD outputs are registered.
- Transaction engine:
  - XSETUP (SETUP_CYC cycles, EN=0, DATA/RS valid) -> XPULSE (EN_CYC, EN=1) -> XHOLD (HOLD_CYC, EN=0, DATA/RS unchanged) -> XWAIT (CMD_WAIT_CYC, or CLR_WAIT_CYC for 0x01).
  - Total = SETUP+EN+HOLD+WAIT cycles.
- Top FSM states: PWR, INIT0..INIT3, IDLE, XFER, WRAP.
  - PWR: count PWR_CYC cycles, then go to INIT0.
  - INIT0..INIT3 send, one per transaction, in order:
    - 0x38 (8-bit; N_ROWS==1 sends 0x30)
    - 0x0F/0x0C (per CURSOR_BLINK)
    - 0x01 (uses CLR wait)
    - 0x06
  - After INIT3 completes: init_done=1, enter IDLE.
  - IDLE: req_ready=1. It is the only state with ready high; ready drops the cycle after acceptance.
- Requests:
  - Request data is sampled on acceptance; later changes are ignored.
  - CHAR: RS=1, DATA=req_data.
    - Then cur_col+1.
    - If cur_col was N_COLS-1: cur_col=0, cur_row=(cur_row+1) mod N_ROWS, and WRAP issues set-DDRAM 0x80|row_base(cur_row) before returning to IDLE.
    - row_base = 0x00, 0x40, 0x14, 0x54 for rows 0..3.
  - LEFT: cur_col>0 -> command 0x10, cur_col-1. cur_col==0 -> no bus activity; ready reasserts next cycle.
  - RIGHT: cur_col<N_COLS-1 -> command 0x14, cur_col+1. At last column -> no-op, same as LEFT at column 0.
  - CLEAR: command 0x01 with CLR wait; cur_row=cur_col=0.
- cur_row/cur_col update when the transaction finishes (entering IDLE or WRAP), not at acceptance.
- req_valid asserted before init_done is simply held off (ready=0). Nothing is dropped.
- Counters are sized $clog2 of the largest cycle parameter. Zero-valued SETUP/HOLD parameters skip their phase.

Decomposition:
- lcd_pkg holds:
  - op enum (OP_CHAR/OP_LEFT/OP_RIGHT/OP_CLEAR)
  - command constants (CMD_CLEAR 0x01, CMD_ENTRY 0x06, CMD_FUNC_8B2L 0x38, CMD_FUNC_8B1L 0x30, CMD_DISP_ON/ON_BLINK, CMD_SHIFT_L 0x10, CMD_SHIFT_R 0x14, CMD_DDRAM 0x80)
  - row_base function
- One sub-module: lcd_bus_xfer.
  - Input: start, rs, data, long_wait.
  - Output: done pulse, LCD pins.
  - Implements the XSETUP..XWAIT timing.
- lcd_text_ctrl keeps init sequencing, request decode and cursor tracking.

Test Plan (bench params: PWR_CYC=20, SETUP=1, EN=2, HOLD=1, CMD_WAIT=4, CLR_WAIT=10):
1. Release reset, no requests -> EN pulses carry 0x38, 0x0F, 0x01, 0x06 with RS=0, EN high exactly 2 cycles each, 0x01 followed by a 10-cycle wait. init_done=1 at the end; req_ready rises the same cycle.
2. CHAR 'A' (0x41) accepted -> one EN pulse with RS=1, DATA=0x41. req_ready low for exactly 8 cycles. cur_col 0->1.
3. N_COLS=16: 16 CHAR requests -> after the 16th data write, a command 0x80|0x40=0xC0 follows. cur_row=1, cur_col=0. Repeat on row 1 -> 0x80, cur_row=0.
4. LEFT at col 0 -> no EN activity, ready high again 1 cycle later. RIGHT at col 3 -> command 0x14, col=4. LEFT -> 0x10, col=3.
5. CLEAR at row 1 col 5 -> command 0x01, ready low 14 cycles, row=col=0.
6. Deassert irst during EN high in a CHAR write -> EN=0, DATA=0 immediately. After release, the full init sequence repeats and col=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD text controller.
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_CHAR  = 2'd0,
        OP_LEFT  = 2'd1,
        OP_RIGHT = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    localparam logic [7:0] CMD_CLEAR         = 8'h01;
    localparam logic [7:0] CMD_ENTRY         = 8'h06;
    localparam logic [7:0] CMD_FUNC_8B2L     = 8'h38;
    localparam logic [7:0] CMD_FUNC_8B1L     = 8'h30;
    localparam logic [7:0] CMD_DISP_ON       = 8'h0C;
    localparam logic [7:0] CMD_DISP_ON_BLINK = 8'h0F;
    localparam logic [7:0] CMD_SHIFT_L       = 8'h10;
    localparam logic [7:0] CMD_SHIFT_R       = 8'h14;
    localparam logic [7:0] CMD_DDRAM         = 8'h80;

    // DDRAM address of column 0 for each display row
    function automatic logic [7:0] row_base(input logic [1:0] row);
        logic [7:0] base;
        case (row)
            2'd0:    base = 8'h00;
            2'd1:    base = 8'h40;
            2'd2:    base = 8'h14;
            default: base = 8'h54;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Request handshake between the text source and the LCD text controller.
interface lcd_text_ctrl_if;
    import lcd_pkg::*;

    logic       req_valid;
    op_e        req_op;
    logic [7:0] req_data;
    logic       req_ready;

    modport master (output req_valid, output req_op, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_op, input  req_data, output req_ready);

endinterface

// File: rtl/lcd_bus_xfer.sv
// One HD44780 bus write: setup, EN pulse, hold, then execution wait; done_c flags the last wait cycle.
module lcd_bus_xfer #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_CYC       = 14,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 1350,
    parameter int unsigned CLR_WAIT_CYC = 54_000
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done_c,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_C > CLR_WAIT_CYC) ? MAX_C : CLR_WAIT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {X_IDLE, X_SETUP, X_PULSE, X_HOLD, X_WAIT} xstate_e;

    xstate_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             long_q, long_d;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= X_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        long_d  = long_q;
        done_c  = 1'b0;
        case (state_q)
            X_IDLE: ;
            X_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = X_PULSE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            X_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = (HOLD_CYC != 0) ? X_HOLD : X_WAIT;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            X_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = X_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            X_WAIT: begin
                if (cnt_q == (long_q ? CLR_LAST : CMD_LAST)) begin
                    state_d = X_IDLE;
                    cnt_d   = '0;
                    done_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = X_IDLE;
        endcase
        // A new write may chain directly onto the final wait cycle of the previous one
        if (start && (state_q == X_IDLE || done_c)) begin
            data_d = data;
            rs_d   = rs;
            long_d = long_wait;
            cnt_d  = '0;
            if (SETUP_CYC != 0) begin
                state_d = X_SETUP;
                en_d    = 1'b0;
            end else begin
                state_d = X_PULSE;
                en_d    = 1'b1;
            end
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: power-up init, request decode and cursor tracking over an 8-bit write-only bus.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned N_COLS       = 16,
    parameter int unsigned N_ROWS       = 2,
    parameter int unsigned PWR_CYC      = 1_080_000,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_CYC       = 14,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 1350,
    parameter int unsigned CLR_WAIT_CYC = 54_000,
    parameter int unsigned CURSOR_BLINK = 1,
    localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int unsigned COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic             iclk,
    input  logic             irst,
    lcd_text_ctrl_if.slave   req,
    output logic             init_done,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic [7:0]       LCD_DATA,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic             LCD_EN
);

    localparam int unsigned PWR_W = $clog2(PWR_CYC + 1);

    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_CYC - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [7:0]       FUNC_CMD = (N_ROWS == 1) ? CMD_FUNC_8B1L : CMD_FUNC_8B2L;
    localparam logic [7:0]       DISP_CMD = (CURSOR_BLINK != 0) ? CMD_DISP_ON_BLINK : CMD_DISP_ON;

    typedef enum logic [2:0] {
        ST_PWR, ST_INIT0, ST_INIT1, ST_INIT2, ST_INIT3, ST_IDLE, ST_XFER, ST_WRAP
    } state_e;

    state_e           state_q, state_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    op_e              op_q, op_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;

    logic       accept_c;
    logic       start_c;
    logic       start_rs_c;
    logic [7:0] start_data_c;
    logic       start_long_c;
    logic       xfer_done_c;

    lcd_bus_xfer #(
        .SETUP_CYC    (SETUP_CYC),
        .EN_CYC       (EN_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_xfer (
        .iclk      (iclk),
        .irst      (irst),
        .start     (start_c),
        .rs        (start_rs_c),
        .data      (start_data_c),
        .long_wait (start_long_c),
        .done_c    (xfer_done_c),
        .lcd_data  (LCD_DATA),
        .lcd_rs    (LCD_RS),
        .lcd_en    (LCD_EN)
    );

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q     <= ST_PWR;
            pwr_cnt_q   <= '0;
            op_q        <= OP_CHAR;
            row_q       <= '0;
            col_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        op_d         = op_q;
        row_d        = row_q;
        col_d        = col_q;
        init_done_d  = init_done_q;
        start_c      = 1'b0;
        start_rs_c   = 1'b0;
        start_data_c = 8'h00;
        start_long_c = 1'b0;
        accept_c     = req.req_valid && ready_q && (state_q == ST_IDLE);
        case (state_q)
            ST_PWR: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d      = ST_INIT0;
                    start_c      = 1'b1;
                    start_data_c = FUNC_CMD;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end
            ST_INIT0: if (xfer_done_c) begin
                state_d      = ST_INIT1;
                start_c      = 1'b1;
                start_data_c = DISP_CMD;
            end
            ST_INIT1: if (xfer_done_c) begin
                state_d      = ST_INIT2;
                start_c      = 1'b1;
                start_data_c = CMD_CLEAR;
                start_long_c = 1'b1;
            end
            ST_INIT2: if (xfer_done_c) begin
                state_d      = ST_INIT3;
                start_c      = 1'b1;
                start_data_c = CMD_ENTRY;
            end
            ST_INIT3: if (xfer_done_c) begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
            end
            ST_IDLE: if (accept_c) begin
                op_d = req.req_op;
                // Cursor moves against the row edges generate no bus traffic
                case (req.req_op)
                    OP_CHAR: begin
                        state_d      = ST_XFER;
                        start_c      = 1'b1;
                        start_rs_c   = 1'b1;
                        start_data_c = req.req_data;
                    end
                    OP_LEFT: if (col_q != '0) begin
                        state_d      = ST_XFER;
                        start_c      = 1'b1;
                        start_data_c = CMD_SHIFT_L;
                    end
                    OP_RIGHT: if (col_q != LAST_COL) begin
                        state_d      = ST_XFER;
                        start_c      = 1'b1;
                        start_data_c = CMD_SHIFT_R;
                    end
                    OP_CLEAR: begin
                        state_d      = ST_XFER;
                        start_c      = 1'b1;
                        start_data_c = CMD_CLEAR;
                        start_long_c = 1'b1;
                    end
                endcase
            end
            ST_XFER: if (xfer_done_c) begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_CHAR: begin
                        if (col_q == LAST_COL) begin
                            col_d        = '0;
                            row_d        = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                            state_d      = ST_WRAP;
                            start_c      = 1'b1;
                            start_data_c = CMD_DDRAM | row_base(2'(row_d));
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                    OP_LEFT:  col_d = col_q - COL_W'(1);
                    OP_RIGHT: col_d = col_q + COL_W'(1);
                    OP_CLEAR: begin
                        col_d = '0;
                        row_d = '0;
                    end
                endcase
            end
            ST_WRAP: if (xfer_done_c) state_d = ST_IDLE;
            default: state_d = ST_PWR;
        endcase
        ready_d = (state_d == ST_IDLE) && !accept_c;
    end

    assign req.req_ready = ready_q;
    assign init_done     = init_done_q;
    assign cur_row       = row_q;
    assign cur_col       = col_q;
    assign LCD_RW        = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: init sequence, chars with wrap, cursor moves, clear and mid-write reset.
module tb_lcd_text_ctrl;
    import lcd_pkg::*;

    logic       iclk = 1'b0;
    logic       irst = 1'b0;
    logic       init_done;
    logic [0:0] cur_row;
    logic [3:0] cur_col;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN;

    lcd_text_ctrl_if req_if ();

    lcd_text_ctrl #(
        .N_COLS(16), .N_ROWS(2), .PWR_CYC(20), .SETUP_CYC(1), .EN_CYC(2),
        .HOLD_CYC(1), .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10), .CURSOR_BLINK(1)
    ) dut (
        .iclk(iclk), .irst(irst), .req(req_if), .init_done(init_done),
        .cur_row(cur_row), .cur_col(cur_col), .LCD_DATA(LCD_DATA),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #5 iclk = ~iclk;

    int n_assert = 0;
    int n_fail   = 0;

    // Bus monitor: {RS,DATA} at each EN rise, EN high length, and rise cycle index
    logic [8:0] bus_q[$];
    int         len_q[$];
    int         rise_q[$];
    int         cyc = 0;
    int         en_len = 0;
    logic       en_prev = 1'b0;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        en_prev <= LCD_EN;
        if (LCD_EN) begin
            en_len <= en_len + 1;
            if (!en_prev) begin
                bus_q.push_back({LCD_RS, LCD_DATA});
                rise_q.push_back(cyc);
            end
        end else if (en_prev) begin
            len_q.push_back(en_len);
            en_len <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_bus(input string tag, input logic [8:0] exp);
        logic [31:0] o;
        o = 32'hDEAD;
        if (bus_q.size() > 0) o = 32'(bus_q.pop_front());
        check(tag, o, 32'(exp));
        if (len_q.size() > 0) check({tag, "_en_len"}, 32'(len_q.pop_front()), 32'd2);
    endtask

    task automatic send(input op_e op, input logic [7:0] d, output int lowcnt);
        req_if.req_valid = 1'b1;
        req_if.req_op    = op;
        req_if.req_data  = d;
        @(posedge iclk);
        #1;
        req_if.req_valid = 1'b0;
        req_if.req_data  = ~d;
        req_if.req_op    = OP_CLEAR;
        lowcnt = 0;
        @(negedge iclk);
        while (!req_if.req_ready && lowcnt < 100) begin
            lowcnt++;
            @(negedge iclk);
        end
    endtask

    task automatic wait_init(input string tag);
        int   n;
        logic prev;
        n    = 0;
        prev = init_done;
        @(negedge iclk);
        while (!req_if.req_ready && n < 500) begin
            prev = init_done;
            n++;
            @(negedge iclk);
        end
        check({tag, "_ready"}, 32'(req_if.req_ready), 32'd1);
        check({tag, "_done_prev"}, 32'(prev), 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd1);
        if (rise_q.size() == 4) begin
            check({tag, "_gap_func"}, 32'(rise_q[1] - rise_q[0]), 32'd8);
            check({tag, "_gap_clear"}, 32'(rise_q[3] - rise_q[2]), 32'd14);
        end else begin
            check({tag, "_pulses"}, 32'(rise_q.size()), 32'd4);
        end
        rise_q.delete();
        pop_bus({tag, "_func"}, 9'h038);
        pop_bus({tag, "_disp"}, 9'h00F);
        pop_bus({tag, "_clear"}, 9'h001);
        pop_bus({tag, "_entry"}, 9'h006);
        check({tag, "_row"}, 32'(cur_row), 32'd0);
        check({tag, "_col"}, 32'(cur_col), 32'd0);
    endtask

    initial begin
        int         lc;
        int         n;
        logic [7:0] ch;

        req_if.req_valid = 1'b0;
        req_if.req_op    = OP_CHAR;
        req_if.req_data  = 8'h00;
        repeat (3) @(negedge iclk);
        check("rst_en", 32'(LCD_EN), 32'd0);
        check("rst_rs", 32'(LCD_RS), 32'd0);
        check("rst_data", 32'(LCD_DATA), 32'd0);
        check("rst_rw", 32'(LCD_RW), 32'd0);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_row", 32'(cur_row), 32'd0);
        check("rst_col", 32'(cur_col), 32'd0);

        // 1: power-up init
        irst = 1'b1;
        wait_init("init");
        rise_q.delete();

        // 2: single char
        send(OP_CHAR, 8'h41, lc);
        check("A_ready_low", 32'(lc), 32'd8);
        pop_bus("A_bus", 9'h141);
        check("A_col", 32'(cur_col), 32'd1);
        check("A_extra", 32'(bus_q.size()), 32'd0);

        // 3: fill row 0 then wrap to row 1, fill row 1 then wrap to row 0
        for (int i = 1; i < 16; i++) begin
            ch = 8'h41 + 8'(i);
            send(OP_CHAR, ch, lc);
            check("r0_ready_low", 32'(lc), (i == 15) ? 32'd16 : 32'd8);
            pop_bus("r0_bus", {1'b1, ch});
        end
        pop_bus("wrap_row1", 9'h0C0);
        check("wrap1_row", 32'(cur_row), 32'd1);
        check("wrap1_col", 32'(cur_col), 32'd0);
        for (int i = 0; i < 16; i++) begin
            ch = 8'h61 + 8'(i);
            send(OP_CHAR, ch, lc);
            pop_bus("r1_bus", {1'b1, ch});
        end
        pop_bus("wrap_row0", 9'h080);
        check("wrap0_row", 32'(cur_row), 32'd0);
        check("wrap0_col", 32'(cur_col), 32'd0);
        check("wrap0_extra", 32'(bus_q.size()), 32'd0);

        // 4: cursor moves
        send(OP_LEFT, 8'h00, lc);
        check("left0_ready_low", 32'(lc), 32'd1);
        check("left0_no_bus", 32'(bus_q.size()), 32'd0);
        check("left0_col", 32'(cur_col), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(OP_CHAR, 8'h30, lc);
            pop_bus("col3_bus", 9'h130);
        end
        check("col3", 32'(cur_col), 32'd3);
        send(OP_RIGHT, 8'h00, lc);
        check("right_ready_low", 32'(lc), 32'd8);
        pop_bus("right_bus", 9'h014);
        check("right_col", 32'(cur_col), 32'd4);
        send(OP_LEFT, 8'h00, lc);
        pop_bus("left_bus", 9'h010);
        check("left_col", 32'(cur_col), 32'd3);

        // 5: clear from row 1 col 5
        for (int i = 0; i < 13; i++) begin
            send(OP_CHAR, 8'h2E, lc);
            pop_bus("to_r1_bus", 9'h12E);
        end
        pop_bus("to_r1_wrap", 9'h0C0);
        check("to_r1_row", 32'(cur_row), 32'd1);
        for (int i = 0; i < 5; i++) begin
            send(OP_RIGHT, 8'h00, lc);
            pop_bus("r1_right_bus", 9'h014);
        end
        check("pre_clear_col", 32'(cur_col), 32'd5);
        send(OP_CLEAR, 8'h00, lc);
        check("clear_ready_low", 32'(lc), 32'd14);
        pop_bus("clear_bus", 9'h001);
        check("clear_row", 32'(cur_row), 32'd0);
        check("clear_col", 32'(cur_col), 32'd0);

        // RIGHT at the last column is a no-op
        for (int i = 0; i < 15; i++) begin
            send(OP_RIGHT, 8'h00, lc);
            pop_bus("to_last_bus", 9'h014);
        end
        send(OP_RIGHT, 8'h00, lc);
        check("right_last_ready_low", 32'(lc), 32'd1);
        check("right_last_no_bus", 32'(bus_q.size()), 32'd0);
        check("right_last_col", 32'(cur_col), 32'd15);

        // 6: reset while EN is high during a data write
        req_if.req_valid = 1'b1;
        req_if.req_op    = OP_CHAR;
        req_if.req_data  = 8'h5A;
        @(posedge iclk);
        #1;
        req_if.req_valid = 1'b0;
        n = 0;
        while (!LCD_EN && n < 50) begin
            @(posedge iclk);
            #1;
            n++;
        end
        check("mid_en_seen", 32'(LCD_EN), 32'd1);
        check("mid_data", 32'({LCD_RS, LCD_DATA}), 32'h15A);
        irst = 1'b0;
        #1;
        check("abort_en", 32'(LCD_EN), 32'd0);
        check("abort_data", 32'(LCD_DATA), 32'd0);
        check("abort_ready", 32'(req_if.req_ready), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge iclk);
        bus_q.delete();
        len_q.delete();
        rise_q.delete();
        irst = 1'b1;
        wait_init("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
